regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback sources:
//  A (ALU result) and B (memory load).
//  - Each source has a valid/ready handshake and a 1-entry holding register.
//  - Round-robin arbitration, with age ordering when both target the same register.
//  - Scoreboard check ports flag pending (not yet written) registers to the decode stage.

---
 rtl/regfile_write_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares one register-file write port between an ALU writeback
//            source (A) and a memory-load writeback source (B). Each source
//            has a valid/ready handshake and a 1-entry holding register.
//            Round-robin between different destinations, age order when both
//            target the same register. Scoreboard ports flag held writes.
// Options  : RF_WB_FWD_EN - adds fwd_data1/fwd_data2 forwarding outputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 5,
  parameter int CNT_W            = 16,
  parameter int ZERO_REG_DISCARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_hit1,
  output logic              chk_hit2,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef RF_WB_FWD_EN
  ,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);

  localparam logic c_DISCARD_R0 = (ZERO_REG_DISCARD != 0);

  // Holding registers and arbitration state
  logic              r_hv_a;
  logic [ADDR_W-1:0] r_addr_a;
  logic [DATA_W-1:0] r_data_a;
  logic              r_hv_b;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_b;
  logic              r_prio;      // 0: A wins next conflict, 1: B wins
  logic              r_a_older;   // held A entry was loaded no later than held B
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_grant_a;
  logic w_grant_b;
  logic w_a_zero;
  logic w_b_zero;
  logic w_a_load;
  logic w_b_load;
  logic w_stall;
  logic w_m_a1;
  logic w_m_b1;
  logic w_m_a2;
  logic w_m_b2;

  // Grant selection: single holder wins; same target goes by age; otherwise round-robin
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!reset) begin
      if (r_hv_a && r_hv_b) begin
        if (r_addr_a == r_addr_b) begin
          w_grant_a = r_a_older;
        end else begin
          w_grant_a = !r_prio;
        end
        w_grant_b = !w_grant_a;
      end else begin
        w_grant_a = r_hv_a;
        w_grant_b = r_hv_b;
      end
    end
  end

  assign w_a_zero = c_DISCARD_R0 && (r_addr_a == '0);
  assign w_b_zero = c_DISCARD_R0 && (r_addr_b == '0);

  // Write port driven straight from the granted holding register; r0 entries drain silently
  always_comb begin
    wr_en   = (w_grant_a && !w_a_zero) || (w_grant_b && !w_b_zero);
    wr_addr = w_grant_a ? r_addr_a : r_addr_b;
    wr_data = w_grant_a ? r_data_a : r_data_b;
  end

  // A holding register may refill in the same cycle it drains
  assign a_ready  = !reset && (!r_hv_a || w_grant_a);
  assign b_ready  = !reset && (!r_hv_b || w_grant_b);
  assign w_a_load = a_valid && a_ready;
  assign w_b_load = b_valid && b_ready;
  assign w_stall  = (a_valid && !a_ready) || (b_valid && !b_ready);

  // Scoreboard matches; discarded r0 entries never count as pending
  assign w_m_a1 = !reset && r_hv_a && !w_a_zero && (r_addr_a == chk_addr1);
  assign w_m_b1 = !reset && r_hv_b && !w_b_zero && (r_addr_b == chk_addr1);
  assign w_m_a2 = !reset && r_hv_a && !w_a_zero && (r_addr_a == chk_addr2);
  assign w_m_b2 = !reset && r_hv_b && !w_b_zero && (r_addr_b == chk_addr2);
  assign chk_hit1 = w_m_a1 || w_m_b1;
  assign chk_hit2 = w_m_a2 || w_m_b2;

`ifdef RF_WB_FWD_EN
  // Forwarding picks the younger entry when both match, since it is the one written last
  always_comb begin
    fwd_data1 = '0;
    fwd_data2 = '0;
    if (w_m_a1 && w_m_b1) begin
      fwd_data1 = r_a_older ? r_data_b : r_data_a;
    end else if (w_m_a1) begin
      fwd_data1 = r_data_a;
    end else if (w_m_b1) begin
      fwd_data1 = r_data_b;
    end
    if (w_m_a2 && w_m_b2) begin
      fwd_data2 = r_a_older ? r_data_b : r_data_a;
    end else if (w_m_a2) begin
      fwd_data2 = r_data_a;
    end else if (w_m_b2) begin
      fwd_data2 = r_data_b;
    end
  end
`endif

  assign stall_cnt = r_stall_cnt;

  // Holding register, priority, age and stall counter updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hv_a      <= 1'b0;
      r_addr_a    <= '0;
      r_data_a    <= '0;
      r_hv_b      <= 1'b0;
      r_addr_b    <= '0;
      r_data_b    <= '0;
      r_prio      <= 1'b0;
      r_a_older   <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      if (w_a_load) begin
        r_hv_a   <= 1'b1;
        r_addr_a <= a_addr;
        r_data_a <= a_data;
      end else if (w_grant_a) begin
        r_hv_a <= 1'b0;
      end
      if (w_b_load) begin
        r_hv_b   <= 1'b1;
        r_addr_b <= b_addr;
        r_data_b <= b_data;
      end else if (w_grant_b) begin
        r_hv_b <= 1'b0;
      end
      if (r_hv_a && r_hv_b) begin
        r_prio <= w_grant_a;
      end
      // A is older unless it loads behind a B entry that stays held
      if (w_a_load) begin
        r_a_older <= w_b_load || !(r_hv_b && !w_grant_b);
      end else if (w_b_load) begin
        r_a_older <= 1'b1;
      end
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. A timestamp-based
//            reference model predicts every output each cycle; directed
//            scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, chk_addr1, chk_addr2, wr_addr;
  logic [DATA_W-1:0] a_data, b_data, wr_data;
  logic              wr_en, chk_hit1, chk_hit2;
  logic [CNT_W-1:0]  stall_cnt;
`ifdef RF_WB_FWD_EN
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
`endif

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ZERO_REG_DISCARD(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .stall_cnt(stall_cnt)
`ifdef RF_WB_FWD_EN
    , .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: held entries tagged with their load cycle
  bit                m_hv[2];
  logic [ADDR_W-1:0] m_addr[2];
  logic [DATA_W-1:0] m_data[2];
  longint            m_ts[2];
  int                m_prio;
  int                m_stall;
  longint            cyc;

  // Snapshot of the outputs sampled during the last step
  logic              s_a_ready, s_b_ready, s_wr_en, s_hit1, s_hit2;
  logic [ADDR_W-1:0] s_wr_addr;
  logic [DATA_W-1:0] s_wr_data, s_fwd1;
  logic [CNT_W-1:0]  s_stall;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic bit m_hit(input logic [ADDR_W-1:0] a);
    if (reset || a == 0) return 1'b0;
    return (m_hv[0] && m_addr[0] == a) || (m_hv[1] && m_addr[1] == a);
  endfunction

  function automatic logic [DATA_W-1:0] m_fwd(input logic [ADDR_W-1:0] a);
    bit h0, h1;
    if (reset || a == 0) return '0;
    h0 = m_hv[0] && m_addr[0] == a;
    h1 = m_hv[1] && m_addr[1] == a;
    if (h0 && h1) return (m_ts[1] >= m_ts[0]) ? m_data[1] : m_data[0];
    if (h0) return m_data[0];
    if (h1) return m_data[1];
    return '0;
  endfunction

  // One clock cycle: predict and compare at negedge, advance the model at posedge
  task automatic step();
    int g;
    bit rdy0, rdy1, e_wr;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      if (m_hv[0] && m_hv[1]) begin
        if (m_addr[0] == m_addr[1]) g = (m_ts[0] <= m_ts[1]) ? 0 : 1;
        else g = m_prio;
      end else if (m_hv[0]) g = 0;
      else if (m_hv[1]) g = 1;
    end
    rdy0 = !reset && (!m_hv[0] || g == 0);
    rdy1 = !reset && (!m_hv[1] || g == 1);
    e_wr = 1'b0;
    if (g >= 0) e_wr = (m_addr[g] != 0);
    check_val("a_ready", a_ready, rdy0);
    check_val("b_ready", b_ready, rdy1);
    check_val("wr_en", wr_en, e_wr);
    if (e_wr) begin
      check_val("wr_addr", wr_addr, m_addr[g]);
      check_val("wr_data", wr_data, m_data[g]);
    end
    check_val("chk_hit1", chk_hit1, m_hit(chk_addr1));
    check_val("chk_hit2", chk_hit2, m_hit(chk_addr2));
    check_val("stall_cnt", stall_cnt, m_stall);
`ifdef RF_WB_FWD_EN
    check_val("fwd_data1", fwd_data1, m_fwd(chk_addr1));
    check_val("fwd_data2", fwd_data2, m_fwd(chk_addr2));
    s_fwd1 = fwd_data1;
`else
    s_fwd1 = '0;
`endif
    s_a_ready = a_ready; s_b_ready = b_ready; s_wr_en = wr_en;
    s_wr_addr = wr_addr; s_wr_data = wr_data;
    s_hit1 = chk_hit1; s_hit2 = chk_hit2; s_stall = stall_cnt;
    @(posedge clk);
    if (reset) begin
      m_hv[0] = 1'b0; m_hv[1] = 1'b0; m_prio = 0; m_stall = 0;
    end else begin
      if ((a_valid && !rdy0) || (b_valid && !rdy1))
        m_stall = (m_stall < (1 << CNT_W) - 1) ? m_stall + 1 : m_stall;
      if (g >= 0) begin
        if (m_hv[0] && m_hv[1]) m_prio = 1 - g;
        m_hv[g] = 1'b0;
      end
      if (a_valid && rdy0) begin
        m_hv[0] = 1'b1; m_addr[0] = a_addr; m_data[0] = a_data; m_ts[0] = cyc;
      end
      if (b_valid && rdy1) begin
        m_hv[1] = 1'b1; m_addr[1] = b_addr; m_data[1] = b_data; m_ts[1] = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_hv[0] = 0; m_hv[1] = 0; m_ts[0] = 0; m_ts[1] = 0;
    m_addr[0] = '0; m_addr[1] = '0; m_data[0] = '0; m_data[1] = '0;
    m_prio = 0; m_stall = 0; cyc = 0;
    reset = 1'b1; idle_inputs(); chk_addr1 = '0; chk_addr2 = '0;
    #1;
    step(); step();
    check_val("rst_a_ready", s_a_ready, 0);
    check_val("rst_wr_en", s_wr_en, 0);
    reset = 1'b0;
    step();
    check_val("post_rst_stall", s_stall, 0);

    // A alone writes r3 <= 12
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd12; chk_addr1 = 5'd3;
    step();
    check_val("t1_a_ready", s_a_ready, 1);
    idle_inputs();
    step();
    check_val("t1_wr_en", s_wr_en, 1);
    check_val("t1_wr_addr", s_wr_addr, 3);
    check_val("t1_wr_data", s_wr_data, 12);
    check_val("t1_hit_on", s_hit1, 1);
    step();
    check_val("t1_hit_off", s_hit1, 0);

    // Both sources every cycle to different registers: writes alternate
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd1; b_addr = 5'd2;
    for (int k = 0; k < 8; k++) begin
      a_data = $urandom; b_data = $urandom;
      step();
      if (k > 0) check_val("t2_alternate", s_wr_addr, (k % 2 == 1) ? 1 : 2);
    end
    idle_inputs();
    step(); step(); step();

    // Same target loaded together: A first, then B
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd5; b_addr = 5'd5;
    a_data = 32'd7; b_data = 32'd9; chk_addr1 = 5'd5;
    step();
    idle_inputs();
    step();
    check_val("t3_first", s_wr_data, 7);
`ifdef RF_WB_FWD_EN
    check_val("t3_fwd_young", s_fwd1, 9);
`endif
    step();
    check_val("t3_second", s_wr_data, 9);
    step();

    // Register 0 write is accepted but discarded
    b_valid = 1'b1; b_addr = '0; b_data = 32'hFFFF; chk_addr2 = '0;
    step();
    check_val("t4_b_ready", s_b_ready, 1);
    idle_inputs();
    step();
    check_val("t4_wr_en", s_wr_en, 0);
    check_val("t4_hit_r0", s_hit2, 0);

    // Sustained contention saturates the stall counter
    reset = 1'b1; step(); reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd1; b_addr = 5'd2;
    for (int k = 0; k < 20; k++) step();
    check_val("t5_saturate", s_stall, 15);

    // Reset right after loading both: held entries are dropped
    idle_inputs();
    reset = 1'b1; step(); reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd6; b_addr = 5'd7;
    a_data = 32'hA5; b_data = 32'h5A;
    step();
    reset = 1'b1;
    step();
    check_val("t6_a_ready_rst", s_a_ready, 0);
    check_val("t6_b_ready_rst", s_b_ready, 0);
    check_val("t6_wr_en_rst", s_wr_en, 0);
    reset = 1'b0; idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("t6_no_write", s_wr_en, 0);
    end

    // Randomized traffic over a small register set to provoke collisions
    for (int k = 0; k < 1500; k++) begin
      reset     = ($urandom_range(0, 99) == 0);
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_addr    = 5'($urandom_range(0, 3));
      b_addr    = 5'($urandom_range(0, 3));
      a_data    = $urandom;
      b_data    = $urandom;
      chk_addr1 = 5'($urandom_range(0, 3));
      chk_addr2 = 5'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
